// File: rtl/data_bus_pkg.sv
// data_bus_pkg: shared types and lane-mask constants for the data bus master
package data_bus_pkg;
  typedef enum logic [1:0] {BYTE, HALF, WORD, ILLEGAL} size_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;
endpackage

// File: rtl/data_bus_if.sv
// data_bus_if: command, response and data-bus signals of the data bus master
interface data_bus_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        cmd_write;
  logic [1:0]  cmd_size;
  logic        cmd_signed;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misaligned;
  logic        rsp_timeout;
  logic [31:0] data_addr;
  logic [31:0] data_data;
  logic [3:0]  data_mask;
  logic        data_wren;
  logic        data_req;
  logic        data_ack;
  logic [31:0] data_q;
  modport master (
    input  cmd_valid, cmd_addr, cmd_wdata, cmd_write, cmd_size, cmd_signed, data_ack, data_q,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_timeout,
           data_addr, data_data, data_mask, data_wren, data_req
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_wdata, cmd_write, cmd_size, cmd_signed, data_ack, data_q,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_misaligned, rsp_timeout,
           data_addr, data_data, data_mask, data_wren, data_req
  );
endinterface

// File: rtl/data_bus_lane_align.sv
// data_bus_lane_align: byte-lane mask, alignment check, store replication and load extension
module data_bus_lane_align
  import data_bus_pkg::*;
(
  input  logic [1:0]  off,
  input  size_t       size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] q,
  output logic [3:0]  mask,
  output logic [31:0] wdata_rep,
  output logic        misaligned,
  output logic [31:0] rdata
);
  logic [31:0] sh;
  // store-side lane placement and load-side right-justify plus extension
  always_comb begin
    misaligned = size == ILLEGAL || (size == HALF && off[0]) || (size == WORD && off != 2'd0);
    mask = size == BYTE ? MASK_BYTE << off : size == HALF ? MASK_HALF << off : MASK_WORD;
    wdata_rep = size == BYTE ? {4{wdata[7:0]}} : size == HALF ? {2{wdata[15:0]}} : wdata;
    sh = q >> {off, 3'b000};
    rdata = size == BYTE ? {{24{sgn & sh[7]}}, sh[7:0]} :
            size == HALF ? {{16{sgn & sh[15]}}, sh[15:0]} : sh;
  end
endmodule

// File: rtl/data_bus_master.sv
// data_bus_master: single-outstanding req/ack data bus initiator with misalignment and timeout reporting
module data_bus_master
  import data_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic reset,
  data_bus_if.master bus
);
  state_t      state;
  logic [15:0] cnt;
  logic [1:0]  lat_off;
  size_t       lat_size;
  logic        lat_sgn;
  logic        lat_write;
  logic        idle;
  logic [1:0]  cur_off;
  size_t       cur_size;
  logic        cur_sgn;
  logic [3:0]  mask;
  logic [31:0] wrep;
  logic [31:0] rdata;
  logic        mis;
  assign idle = state == IDLE;
  assign cur_off = idle ? bus.cmd_addr[1:0] : lat_off;
  assign cur_size = idle ? size_t'(bus.cmd_size) : lat_size;
  assign cur_sgn = idle ? bus.cmd_signed : lat_sgn;
  data_bus_lane_align u_align (
    .off(cur_off),
    .size(cur_size),
    .sgn(cur_sgn),
    .wdata(bus.cmd_wdata),
    .q(bus.data_q),
    .mask(mask),
    .wdata_rep(wrep),
    .misaligned(mis),
    .rdata(rdata)
  );
  // transaction FSM with timeout counter; every output is registered here
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      lat_off <= '0;
      lat_size <= BYTE;
      lat_sgn <= 1'b0;
      lat_write <= 1'b0;
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_misaligned <= 1'b0;
      bus.rsp_timeout <= 1'b0;
      bus.data_addr <= '0;
      bus.data_data <= '0;
      bus.data_mask <= '0;
      bus.data_wren <= 1'b0;
      bus.data_req <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) begin
          lat_off <= bus.cmd_addr[1:0];
          lat_size <= size_t'(bus.cmd_size);
          lat_sgn <= bus.cmd_signed;
          lat_write <= bus.cmd_write;
          cnt <= '0;
          bus.cmd_ready <= 1'b0;
          if (mis) begin
            state <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_misaligned <= 1'b1;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_rdata <= '0;
          end else begin
            state <= ISSUE;
            bus.data_req <= 1'b1;
            bus.data_addr <= {bus.cmd_addr[31:2], 2'b00};
            bus.data_data <= wrep;
            bus.data_mask <= mask;
            bus.data_wren <= bus.cmd_write;
          end
        end
        ISSUE, WAIT: begin
          bus.data_req <= 1'b0;
          if (bus.data_ack) begin
            state <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= lat_write ? '0 : rdata;
            bus.rsp_misaligned <= 1'b0;
            bus.rsp_timeout <= 1'b0;
          end else if (state == WAIT && cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            state <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= '0;
            bus.rsp_misaligned <= 1'b0;
            bus.rsp_timeout <= 1'b1;
          end else begin
            state <= WAIT;
            cnt <= cnt + 16'(state == WAIT);
          end
        end
        RESP: begin
          state <= IDLE;
          bus.cmd_ready <= 1'b1;
          bus.rsp_valid <= 1'b0;
          bus.rsp_misaligned <= 1'b0;
          bus.rsp_timeout <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_bus_master.sv
// tb_data_bus_master: randomized and directed checks of data_bus_master against a behavioural model
module tb_data_bus_master;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  data_bus_if bus ();
  data_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] m_mask(input logic [31:0] addr, input logic [1:0] sz);
    int n = 1 << sz;
    return 4'(((1 << n) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] m_data(input logic [31:0] wdata, input logic [1:0] sz);
    logic [31:0] r;
    int n = 1 << sz;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wdata[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] addr, input logic [1:0] sz, input logic sg, input logic [31:0] q);
    int n = 1 << sz;
    logic [63:0] keep = (64'd1 << (8 * n)) - 1;
    logic [63:0] v = (64'(q) >> (8 * (addr % 4))) & keep;
    if (sg && v[8*n-1]) v = v | ~keep;
    return v[31:0];
  endfunction

  task automatic check_reset();
    check("rst cmd_ready", bus.cmd_ready, 1);
    check("rst rsp_valid", bus.rsp_valid, 0);
    check("rst rsp_misaligned", bus.rsp_misaligned, 0);
    check("rst rsp_timeout", bus.rsp_timeout, 0);
    check("rst rsp_rdata", bus.rsp_rdata, 0);
    check("rst data_req", bus.data_req, 0);
    check("rst data_wren", bus.data_wren, 0);
    check("rst data_addr", bus.data_addr, 0);
    check("rst data_data", bus.data_data, 0);
    check("rst data_mask", bus.data_mask, 0);
  endtask

  task automatic scramble_cmd();
    bus.cmd_addr = $urandom;
    bus.cmd_wdata = $urandom;
    bus.cmd_write = 1'($urandom);
    bus.cmd_size = 2'($urandom);
    bus.cmd_signed = 1'($urandom);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      check("idle cmd_ready", bus.cmd_ready, 1);
      check("idle rsp_valid", bus.rsp_valid, 0);
      bus.cmd_valid = 1'b0;
      bus.data_ack = 1'($urandom);
      bus.data_q = $urandom;
      scramble_cmd();
    end
  endtask

  task automatic txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] q,
                     input logic wr, input logic [1:0] sz, input logic sg, input int d);
    logic mis = sz == 2'd3 || (addr % (32'd1 << sz)) != 0;
    logic acked = !mis && d <= TO;
    int last = mis ? 1 : (acked ? 1 + d : TO + 1);
    int rc = mis ? 1 : (acked ? 2 + d : TO + 2);
    logic [31:0] lanes = 0;
    logic [31:0] exp_rd = (mis || wr || !acked) ? 32'd0 : m_load(addr, sz, sg, q);
    if (!mis) for (int i = 0; i < 4; i++) if (m_mask(addr, sz)[i]) lanes[8*i +: 8] = 8'hff;
    @(negedge clk);
    check("accept cmd_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_write = wr;
    bus.cmd_size = sz;
    bus.cmd_signed = sg;
    bus.data_ack = 1'($urandom);
    bus.data_q = $urandom;
    for (int c = 1; c <= rc; c++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      scramble_cmd();
      check("data_req", bus.data_req, c == 1 && !mis);
      if (!mis && c <= last) begin
        check("data_addr", bus.data_addr, {addr[31:2], 2'b00});
        check("data_mask", bus.data_mask, m_mask(addr, sz));
        check("data_wren", bus.data_wren, wr);
        if (wr) check("data_data", bus.data_data, m_data(wdata, sz));
      end
      check("rsp_valid", bus.rsp_valid, c == rc);
      if (c == rc) begin
        check("rsp_rdata", bus.rsp_rdata, exp_rd);
        check("rsp_misaligned", bus.rsp_misaligned, mis);
        check("rsp_timeout", bus.rsp_timeout, !mis && !acked);
        check("busy cmd_ready", bus.cmd_ready, 0);
      end
      bus.data_ack = (acked && c == 1 + d) ? 1'b1 : (c > last) ? 1'($urandom) : 1'b0;
      bus.data_q = (acked && c == 1 + d) ? ((q & lanes) | ($urandom & ~lanes)) : $urandom;
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.data_ack = 1'b0;
    bus.data_q = '0;
    scramble_cmd();
    repeat (3) @(negedge clk);
    check_reset();
    reset = 1'b0;
    txn(32'h100, 32'hDEADBEEF, 0, 1, 2, 0, 1);
    txn(32'h103, 0, 32'h80FFFFFF, 0, 0, 1, 1);
    txn(32'h103, 0, 32'h80FFFFFF, 0, 0, 0, 1);
    txn(32'h102, 32'h00001234, 0, 1, 1, 0, 1);
    txn(32'h102, 0, 32'h80010000, 0, 1, 1, 1);
    txn(32'h101, 32'h5555, 0, 1, 1, 0, 1);
    txn(32'h0, 0, 32'h12345678, 0, 3, 0, 1);
    txn(32'h200, 0, 32'h12345678, 0, 2, 0, 99);
    idle(3);
    txn(32'h204, 0, 32'hCAFEF00D, 0, 2, 0, 2);
    txn(32'h208, 0, 32'hA5A5FF7F, 0, 0, 1, 0);
    txn(32'h20A, 0, 32'h9000ABCD, 0, 1, 1, TO);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = 32'h300;
    bus.cmd_write = 1'b1;
    bus.cmd_size = 2'd2;
    bus.cmd_wdata = 32'h11223344;
    bus.data_ack = 1'b0;
    @(negedge clk);
    check("rstwait data_req", bus.data_req, 1);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("rstwait rsp_valid", bus.rsp_valid, 0);
    reset = 1'b1;
    bus.data_ack = 1'b1;
    @(negedge clk);
    check_reset();
    reset = 1'b0;
    idle(3);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a = $urandom;
      logic [1:0] s = 2'($urandom);
      if ($urandom_range(0, 3) != 0 && s != 2'd3) a = a & ~((32'd1 << s) - 1);
      txn(a, $urandom, $urandom, 1'($urandom), s, 1'($urandom), int'($urandom_range(0, TO + 2)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
